bcd_counter_4digit: RTL and testbench
=====================================

BCD_COUNTER_4DIGIT -- requirements
Module: bcd_counter_4digit

Interface
REQ-001 The block SHALL have parameter DIV, default 4, giving the clock cycles per count step when prescaling is compiled in (legal range 2..65535).
REQ-002 The block SHALL use one clock and a synchronous, active-high reset.
REQ-003 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: count enable.
REQ-006 The block SHALL have port up, input, 1 bit: direction, 1 = increment and 0 = decrement.
REQ-007 The block SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 The block SHALL have ports ld0, ld1, ld2, ld3, input, 4 bits each: load values, units through thousands.
REQ-009 The block SHALL have ports q0, q1, q2, q3, output, 4 bits each: registered BCD digits, units through thousands, driving the downstream 7-segment decoder inputs x0..x3 directly.
REQ-010 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on a roll-over.

Function
REQ-011 Outputs q0..q3 SHALL always hold values 0..9; no other digit value SHALL ever appear.
REQ-012 Priority per cycle SHALL be: rst, then load, then count step, then hold.
REQ-013 On load=1, each digit SHALL take ldN, or 0 where ldN > 9, at the next edge.
REQ-014 On load=1, the prescaler SHALL clear and wrap SHALL be 0, regardless of en.
REQ-015 A count step SHALL occur only on a cycle where en=1 and step_tick=1; step_tick is defined under Configuration.
REQ-016 An up step SHALL increment q0; a digit at 9 SHALL go to 0 and carry into the next digit; carries SHALL ripple through all four digits in the same cycle.
REQ-017 A down step SHALL decrement q0; a digit at 0 SHALL go to 9 and borrow from the next digit; borrows SHALL ripple in the same cycle.
REQ-018 An up step from 9999 SHALL give 0000, and a down step from 0000 SHALL give 9999.
REQ-019 wrap SHALL be registered and high for exactly the one cycle in which q shows the wrapped value (0000 after up, 9999 after down); it SHALL be 0 otherwise.
REQ-020 Output latency SHALL be one clock from the qualifying edge; the outputs SHALL have no combinational path from any input.
REQ-021 With en=0, the digits and the prescaler SHALL hold, and wrap SHALL be 0.
REQ-022 A change of up between steps SHALL take effect on the next step, with no extra cycles.

Reset
REQ-023 On rst=1 at a clock edge, q0..q3 SHALL become 0, wrap SHALL become 0, and the prescaler SHALL become 0, overriding load and en.
REQ-024 A reset during counting SHALL discard any partial prescale; the first step after reset release SHALL follow the full prescale period.

Configuration
REQ-025 The macro BCD_PRESCALE_EN SHALL select the step rate.
REQ-026 With BCD_PRESCALE_EN defined, a prescaler counter of width ceil(log2(DIV)) SHALL advance on each en=1 cycle. step_tick SHALL be 1 when the counter equals DIV-1, and the counter SHALL then return to 0. One step SHALL therefore occur every DIV enabled cycles.
REQ-027 Without BCD_PRESCALE_EN, step_tick SHALL be constantly 1, DIV SHALL be ignored, no prescaler register SHALL exist, and each en=1 cycle SHALL step.

Verification
REQ-028 Reset: rst=1 for 2 cycles with load=1 and ld=9,9,9,9 -> q=0000 and wrap=0 after release.
REQ-029 Up count (without macro): en=1, up=1 from 9998 for 2 cycles -> 9999, then 0000 with wrap=1 for exactly that cycle.
REQ-030 Down count: load 1000, then en=1, up=0 for 1 cycle -> 0999; from 0000, one step -> 9999 with wrap=1.
REQ-031 Load clamp and priority: load=1, en=1, ld0..ld3=5,12,3,15 -> q0..q3=5,0,3,0 and no step that cycle.
REQ-032 Prescale (macro defined, DIV=4): en=1 from 0000 for 12 cycles -> q0 steps at enabled cycles 4, 8 and 12, giving 0003. Dropping en for 3 cycles mid-period SHALL delay the next step by 3 cycles.
REQ-033 Random: 200 cycles of random en, up and load, checked against a decimal reference model modulo 10000 -> every digit <= 9, and wrap occurs only on a roll-over.

Source files
------------

// File: rtl/bcd_counter_4digit.sv
// Four-digit BCD up/down counter with parallel load and a registered roll-over pulse.
// Define BCD_PRESCALE_EN to step once every DIV enabled cycles instead of every enabled cycle.
module bcd_counter_4digit #(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] ld0,
   input  logic [3:0] ld1,
   input  logic [3:0] ld2,
   input  logic [3:0] ld3,
   output logic [3:0] q0,
   output logic [3:0] q1,
   output logic [3:0] q2,
   output logic [3:0] q3,
   output logic       wrap
);

   if (DIV < 2 || DIV > 65535) begin : g_bad_div
      $error("bcd_counter_4digit: DIV must be in 2..65535");
   end

   logic [3:0] dig [4];
   logic [3:0] nxt [4];
   logic [3:0] ld  [4];
   logic [3:0] nine;
   logic [3:0] zero;
   logic [3:0] hit;
   logic [3:0] adv;
   logic       step_tick;

`ifdef BCD_PRESCALE_EN
   localparam int PW = $clog2(DIV);
   logic [PW-1:0] pre;

   assign step_tick = (pre == PW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || load) begin
         pre <= '0;
      end else if (en) begin
         pre <= step_tick ? '0 : pre + 1'b1;
      end
   end
`else
   assign step_tick = 1'b1;
`endif

   assign ld[0] = ld0;
   assign ld[1] = ld1;
   assign ld[2] = ld2;
   assign ld[3] = ld3;

   // hit marks digits at their roll-over value for the current direction;
   // a digit advances when every lower digit is at roll-over (flat, no chain).
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nine[i] = (dig[i] == 4'd9);
         zero[i] = (dig[i] == 4'd0);
      end
   end

   assign hit = up ? nine : zero;
   assign adv = {&hit[2:0], &hit[1:0], hit[0], 1'b1};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nxt[i] = dig[i];
         if (adv[i]) begin
            if (up) begin
               nxt[i] = nine[i] ? 4'd0 : dig[i] + 4'd1;
            end else begin
               nxt[i] = zero[i] ? 4'd9 : dig[i] - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) dig[i] <= 4'd0;
         wrap <= 1'b0;
      end else if (load) begin
         for (int i = 0; i < 4; i++) dig[i] <= (ld[i] > 4'd9) ? 4'd0 : ld[i];
         wrap <= 1'b0;
      end else if (en && step_tick) begin
         for (int i = 0; i < 4; i++) dig[i] <= nxt[i];
         wrap <= &hit;
      end else begin
         wrap <= 1'b0;
      end
   end

   assign q0 = dig[0];
   assign q1 = dig[1];
   assign q2 = dig[2];
   assign q3 = dig[3];

endmodule

// File: tb/tb_bcd_counter_4digit.sv
// Bench for bcd_counter_4digit: decimal reference model (value modulo 10000) with a
// per-cycle expected queue, directed boundary cases and randomized traffic.
module tb_bcd_counter_4digit;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       load = 1'b0;
   logic [3:0] ld0 = '0, ld1 = '0, ld2 = '0, ld3 = '0;
   logic [3:0] q0, q1, q2, q3;
   logic       wrap;

   int n_checks = 0;
   int n_fail = 0;
   bit chk_on = 1'b0;

   int m_val = 0;
   int m_pre = 0;
   logic [14:0] exp_q[$];

   bcd_counter_4digit #(.DIV(DIV)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .ld0(ld0), .ld1(ld1), .ld2(ld2), .ld3(ld3),
      .q0(q0), .q1(q1), .q2(q2), .q3(q3), .wrap(wrap)
   );

   // clock / reset
   always #5 clk = ~clk;

   // reference model
   function automatic int clampd(input logic [3:0] d);
      return (d > 4'd9) ? 0 : int'(d);
   endfunction

   function automatic bit tick(input int pre);
`ifdef BCD_PRESCALE_EN
      return pre == DIV - 1;
`else
      return 1'b1;
`endif
   endfunction

   function automatic int next_val(input int v, input int pre);
      if (rst) return 0;
      if (load) return clampd(ld3) * 1000 + clampd(ld2) * 100 + clampd(ld1) * 10 + clampd(ld0);
      if (en && tick(pre)) return up ? (v + 1) % 10000 : (v + 9999) % 10000;
      return v;
   endfunction

   function automatic bit next_wrap(input int v, input int pre);
      if (rst || load || !en || !tick(pre)) return 1'b0;
      return up ? (v == 9999) : (v == 0);
   endfunction

   function automatic int next_pre(input int pre);
      if (rst || load) return 0;
      if (en) return tick(pre) ? 0 : pre + 1;
      return pre;
   endfunction

   always @(posedge clk) begin
      m_val <= next_val(m_val, m_pre);
      m_pre <= next_pre(m_pre);
      exp_q.push_back({next_wrap(m_val, m_pre), 14'(next_val(m_val, m_pre))});
   end

   // scoreboard
   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int dut_val();
      return int'(q3) * 1000 + int'(q2) * 100 + int'(q1) * 10 + int'(q0);
   endfunction

   always @(negedge clk) begin
      logic [14:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (chk_on) begin
            check("q_model", dut_val(), int'(e[13:0]));
            check("wrap_model", int'(wrap), int'(e[14]));
            check("digit_range", int'(q0 <= 9 && q1 <= 9 && q2 <= 9 && q3 <= 9), 1);
         end
      end
   end

   // driver: apply inputs for one clock, return at the following negedge
   task automatic cyc(input logic r, input logic l, input logic e, input logic u,
                      input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
      rst = r; load = l; en = e; up = u;
      ld0 = a; ld1 = b; ld2 = c; ld3 = d;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      // reset overrides load of 9999
      cyc(1, 1, 1, 1, 9, 9, 9, 9);
      chk_on = 1'b1;
      cyc(1, 1, 1, 1, 9, 9, 9, 9);
      check("reset_q", dut_val(), 0);
      check("reset_wrap", int'(wrap), 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      check("release_q", dut_val(), 0);

`ifndef BCD_PRESCALE_EN
      cyc(0, 1, 0, 0, 8, 9, 9, 9);
      check("load_9998", dut_val(), 9998);
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      check("up_9999", dut_val(), 9999);
      check("up_9999_wrap", int'(wrap), 0);
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      check("up_wrap_q", dut_val(), 0);
      check("up_wrap_pulse", int'(wrap), 1);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      check("wrap_one_cycle", int'(wrap), 0);
      check("hold_q", dut_val(), 0);

      cyc(0, 1, 0, 0, 0, 0, 0, 1);
      check("load_1000", dut_val(), 1000);
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      check("down_0999", dut_val(), 999);
      check("down_borrow_wrap", int'(wrap), 0);
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 0, 0, 0);
      check("down_wrap_q", dut_val(), 9999);
      check("down_wrap_pulse", int'(wrap), 1);

      // load beats count; out-of-range digits clamp to 0
      cyc(0, 1, 1, 1, 5, 12, 3, 15);
      check("clamp_q0", int'(q0), 5);
      check("clamp_q1", int'(q1), 0);
      check("clamp_q2", int'(q2), 3);
      check("clamp_q3", int'(q3), 0);
      check("clamp_wrap", int'(wrap), 0);
`else
      cyc(0, 1, 0, 0, 0, 0, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         cyc(0, 0, 1, 1, 0, 0, 0, 0);
         if (k == 4) check("pre_step4", dut_val(), 1);
         if (k == 8) check("pre_step8", dut_val(), 2);
         if (k == 12) check("pre_step12", dut_val(), 3);
      end
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      check("pre_gap_nostep", dut_val(), 3);
      cyc(0, 0, 1, 1, 0, 0, 0, 0);
      check("pre_gap_step", dut_val(), 4);
      cyc(1, 0, 1, 1, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) cyc(0, 0, 1, 0, 0, 0, 0, 0);
      check("pre_after_reset", dut_val(), 9999);
      check("pre_after_reset_wrap", int'(wrap), 1);
`endif

      // randomized traffic, loads biased toward the roll-over boundaries
      for (int i = 0; i < 200; i++) begin
         logic [3:0] a, b, c, d;
         int sel;
         sel = $urandom_range(0, 3);
         a = $urandom_range(0, 15); b = $urandom_range(0, 15);
         c = $urandom_range(0, 15); d = $urandom_range(0, 15);
         if (sel == 0) begin a = 9; b = 9; c = 9; d = 9; end
         if (sel == 1) begin a = 0; b = 0; c = 0; d = 0; end
         cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1, a, b, c, d);
      end
      cyc(0, 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
